dcache_frontend_responder: RTL and testbench
============================================

Name: dcache_frontend_responder

Overview:
- Responder end of the D-cache frontend request/ack protocol driven by the CPU/DMA/FPU port arbiter.
- Direct-mapped, write-through, no-write-allocate data cache with one 16-bit word per line.
- Serves frontend requests from local arrays on a hit; otherwise issues a single-word transaction on the backend memory port, which uses the same access/ack protocol.
- Sits between the arbiter output and the memory/SDRAM arbiter.

Parameters:
- INDEX_BITS, 6, line index width; LINES = 2**INDEX_BITS; TAG_BITS = 19 - INDEX_BITS.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
fe_addr  in  19 [19:1]  word address from arbiter
fe_wdata  in  16  write data from arbiter
fe_access  in  1  request strobe, held until fe_ack
fe_wr_en  in  1  1 = write, 0 = read
fe_bytesel  in  2  byte enables: [0] low byte, [1] high byte
fe_rdata  out  16  read data, valid while fe_ack = 1
fe_ack  out  1  one-cycle completion pulse
mem_addr  out  19 [19:1]  backend word address
mem_wdata  out  16  backend write data
mem_rdata  in  16  backend read data, valid with mem_ack
mem_access  out  1  backend request strobe
mem_ack  in  1  backend completion pulse
mem_wr_en  out  1  backend write enable
mem_bytesel  out  2  backend byte enables

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is synchronous, active-high.
  - On reset: state = IDLE; all valid bits = 0; fe_ack = 0; fe_rdata = 0; mem_access = 0; mem_wr_en = 0; mem_bytesel = 2'b11; mem_addr = 0; mem_wdata = 0.
  - Reset asserted mid-transaction abandons it: mem_access is low from the next cycle and no fe_ack is issued. The backend must tolerate this.
- Outputs: every output is registered.
- States: IDLE, LOOKUP, RD_MISS, WR_THRU, GAP.
- IDLE:
  - fe_access = 1 → latch addr, wdata, wr_en and bytesel into request registers; go to LOOKUP.
- LOOKUP: index = addr[INDEX_BITS:1]; tag = addr[19:INDEX_BITS+1]; hit = valid[index] && tag match.
  - Read hit → fe_rdata <= data[index], fe_ack <= 1; go to GAP.
  - Read miss → mem_access <= 1, mem_wr_en <= 0, mem_bytesel <= 2'b11, mem_addr <= request addr; go to RD_MISS.
  - Any write → mem_access <= 1, mem_wr_en <= 1, mem_bytesel / mem_wdata / mem_addr <= request values; go to WR_THRU.
- RD_MISS:
  - Waits for mem_ack.
  - On mem_ack: data[index] <= mem_rdata, tag written, valid set; fe_rdata <= mem_rdata; fe_ack <= 1; mem_access <= 0; go to GAP.
- WR_THRU:
  - Waits for mem_ack.
  - On mem_ack: if the line hit (hit recomputed or held from LOOKUP), merge the enabled bytes of wdata into data[index]; a write miss does not allocate.
  - Then fe_ack <= 1, mem_access <= 0, go to GAP.
- GAP:
  - fe_ack <= 0.
  - fe_access is ignored for exactly this one cycle, because the arbiter keeps access asserted for one cycle after the ack.
  - Go to IDLE.
- fe_ack is high for exactly one cycle per request.
- Latency, counted from the edge at which IDLE samples fe_access:
  - read hit: fe_ack visible after 2 edges;
  - miss or write: fe_ack on the edge after mem_ack is sampled.
- Backend handshake: mem_access stays high until mem_ack is sampled and goes low on that same edge. mem_addr, mem_wdata, mem_wr_en and mem_bytesel are stable while mem_access = 1.
- Boundary cases:
  - mem_ack in any state other than RD_MISS or WR_THRU is ignored.
  - fe_bytesel is ignored on reads; the full word is always returned.
  - A write with fe_bytesel = 00 is still forwarded to the backend and acked; the line is unchanged.
  - Requests arriving back-to-back are served in order, with the mandatory GAP cycle between them.
  - All LINES indexes are reachable; 19-bit addresses wrap naturally, with no special case at 7FFFF.

Optional Feature:
- Macro: DCACHE_RESP_STATS_EN.
- Defined:
  - Adds outputs stat_rd_hits, stat_rd_misses, stat_writes (each 32 bit).
  - Counters increment on the edge fe_ack is issued for the matching request class.
  - Counters saturate at FFFFFFFF and are cleared by reset.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package dcache_resp_pkg holds:
  - state_t enum (3 bits);
  - ADDR_W = 19 and DATA_W = 16 constants;
  - function merge_bytes(old, new, bytesel) returning the 16-bit merge.
- Sub-module dcache_resp_store holds the valid/tag/data arrays:
  - one read port: combinational read by index;
  - one write port with fill and byte-merge controls;
  - synchronous clear of all valid bits on reset.

Test Plan:
- After reset, read 0x01234 with backend returning 0xBEEF after 3 cycles → one mem_access read at addr 0x01234 with bytesel 11; fe_ack one cycle after mem_ack, with fe_rdata = 0xBEEF.
- Repeat that read → no mem_access; fe_ack 2 edges after sampling; fe_rdata = 0xBEEF.
- Write 0x12AB to 0x01234 with bytesel 01 → backend write with bytesel 01 and data 0x12AB; a following read returns 0xBEAB with no backend access.
- Write miss to 0x05678, then read 0x05678 → the read misses (no allocate) and the backend is accessed.
- Hold fe_access high one cycle after fe_ack (arbiter behaviour) → no second ack and no second backend access; a read of an aliasing address (same index, different tag) then evicts the line and refetches.
- Assert reset during RD_MISS before mem_ack → mem_access low the next cycle, no fe_ack, and a subsequent read of the previously cached 0x01234 misses.

Source files
------------

// File: rtl/dcache_resp_pkg.sv
// Shared types and helpers for the D-cache frontend responder.
// Holds the FSM state encoding, bus widths and the byte-merge function.
package dcache_resp_pkg;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        RD_MISS,
        WR_THRU,
        GAP
    } state_t;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [1:0]        bytesel
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        if (bytesel[0]) res[7:0]  = new_word[7:0];
        if (bytesel[1]) res[15:8] = new_word[15:8];
        return res;
    endfunction

endpackage

// File: rtl/dcache_frontend_responder_if.sv
// Access/ack word bus shared by the frontend and backend sides.
// The master issues requests; the slave returns data and the ack pulse.
interface dcache_frontend_responder_if;
    import dcache_resp_pkg::*;

    logic [ADDR_W:1]   addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              access;
    logic              ack;
    logic              wr_en;
    logic [1:0]        bytesel;

    modport master (
        output addr, wdata, access, wr_en, bytesel,
        input  rdata, ack
    );

    modport slave (
        input  addr, wdata, access, wr_en, bytesel,
        output rdata, ack
    );

endinterface

// File: rtl/dcache_resp_store.sv
// Valid/tag/data arrays of the direct-mapped cache.
// Combinational read by index; one write port for fill or byte merge.
module dcache_resp_store
    import dcache_resp_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = ADDR_W - INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [DATA_W-1:0]     rd_data,
    input  logic                  fill_en,
    input  logic                  merge_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [1:0]            wr_bytesel
);

    localparam int LINES = 2 ** INDEX_BITS;

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tags [LINES];
    logic [DATA_W-1:0]   data [LINES];

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = data[rd_index];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else if (fill_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag/data need no reset: they are only observed through valid.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tags[wr_index] <= wr_tag;
            data[wr_index] <= wr_data;
        end else if (merge_en) begin
            data[wr_index] <= merge_bytes(data[wr_index], wr_data, wr_bytesel);
        end
    end

endmodule

// File: rtl/dcache_frontend_responder.sv
// Write-through, no-write-allocate D-cache responder, one word per line.
// Build option DCACHE_RESP_STATS_EN adds saturating access counters.
module dcache_frontend_responder
    import dcache_resp_pkg::*;
#(
    parameter int INDEX_BITS = 6
) (
    input  logic clk,
    input  logic reset,
    dcache_frontend_responder_if.slave  fe,
    dcache_frontend_responder_if.master mem
`ifdef DCACHE_RESP_STATS_EN
    ,
    output logic [31:0] stat_rd_hits,
    output logic [31:0] stat_rd_misses,
    output logic [31:0] stat_writes
`endif
);

    localparam int TAG_BITS = ADDR_W - INDEX_BITS;

    state_t state_q, state_d;

    logic [ADDR_W:1]   req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_wr;
    logic [1:0]        req_bsel;
    logic              req_load;

    logic              ack_q, ack_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              macc_q, macc_d;
    logic              mwr_q, mwr_d;
    logic [1:0]        mbsel_q, mbsel_d;
    logic [ADDR_W:1]   maddr_q, maddr_d;
    logic [DATA_W-1:0] mwdata_q, mwdata_d;

    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  line_valid;
    logic [TAG_BITS-1:0]   line_tag;
    logic [DATA_W-1:0]     line_data;
    logic                  hit;
    logic                  fill, merge;

    assign req_index = req_addr[INDEX_BITS:1];
    assign req_tag   = req_addr[ADDR_W:INDEX_BITS+1];
    assign hit       = line_valid && (line_tag == req_tag);

    dcache_resp_store #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_store (
        .clk        (clk),
        .reset      (reset),
        .rd_index   (req_index),
        .rd_valid   (line_valid),
        .rd_tag     (line_tag),
        .rd_data    (line_data),
        .fill_en    (fill && !reset),
        .merge_en   (merge && !reset),
        .wr_index   (req_index),
        .wr_tag     (req_tag),
        .wr_data    (fill ? mem.rdata : req_wdata),
        .wr_bytesel (req_bsel)
    );

    always_comb begin
        state_d  = state_q;
        req_load = 1'b0;
        ack_d    = 1'b0;
        rdata_d  = rdata_q;
        macc_d   = macc_q;
        mwr_d    = mwr_q;
        mbsel_d  = mbsel_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        fill     = 1'b0;
        merge    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fe.access) begin
                    req_load = 1'b1;
                    state_d  = LOOKUP;
                end
            end
            LOOKUP: begin
                if (req_wr) begin
                    macc_d   = 1'b1;
                    mwr_d    = 1'b1;
                    mbsel_d  = req_bsel;
                    maddr_d  = req_addr;
                    mwdata_d = req_wdata;
                    state_d  = WR_THRU;
                end else if (hit) begin
                    rdata_d = line_data;
                    ack_d   = 1'b1;
                    state_d = GAP;
                end else begin
                    macc_d  = 1'b1;
                    mwr_d   = 1'b0;
                    mbsel_d = 2'b11;
                    maddr_d = req_addr;
                    state_d = RD_MISS;
                end
            end
            RD_MISS: begin
                if (mem.ack) begin
                    fill    = 1'b1;
                    rdata_d = mem.rdata;
                    ack_d   = 1'b1;
                    macc_d  = 1'b0;
                    state_d = GAP;
                end
            end
            WR_THRU: begin
                if (mem.ack) begin
                    merge   = hit;
                    ack_d   = 1'b1;
                    macc_d  = 1'b0;
                    state_d = GAP;
                end
            end
            // Arbiter still holds access here; drop it on the floor.
            GAP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            req_addr  <= '0;
            req_wdata <= '0;
            req_wr    <= 1'b0;
            req_bsel  <= 2'b11;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            macc_q    <= 1'b0;
            mwr_q     <= 1'b0;
            mbsel_q   <= 2'b11;
            maddr_q   <= '0;
            mwdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            macc_q   <= macc_d;
            mwr_q    <= mwr_d;
            mbsel_q  <= mbsel_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            if (req_load) begin
                req_addr  <= fe.addr;
                req_wdata <= fe.wdata;
                req_wr    <= fe.wr_en;
                req_bsel  <= fe.bytesel;
            end
        end
    end

    assign fe.ack       = ack_q;
    assign fe.rdata     = rdata_q;
    assign mem.access   = macc_q;
    assign mem.wr_en    = mwr_q;
    assign mem.bytesel  = mbsel_q;
    assign mem.addr     = maddr_q;
    assign mem.wdata    = mwdata_q;

`ifdef DCACHE_RESP_STATS_EN
    logic inc_hit, inc_miss, inc_wr;

    assign inc_hit  = (state_q == LOOKUP) && !req_wr && hit;
    assign inc_miss = (state_q == RD_MISS) && mem.ack;
    assign inc_wr   = (state_q == WR_THRU) && mem.ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_rd_hits   <= '0;
            stat_rd_misses <= '0;
            stat_writes    <= '0;
        end else begin
            if (inc_hit && stat_rd_hits != '1)
                stat_rd_hits <= stat_rd_hits + 32'd1;
            if (inc_miss && stat_rd_misses != '1)
                stat_rd_misses <= stat_rd_misses + 32'd1;
            if (inc_wr && stat_writes != '1)
                stat_writes <= stat_writes + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_frontend_responder.sv
// Directed bench for dcache_frontend_responder with an inline backend.
// Expected values are hand-computed per step.
module tb_dcache_frontend_responder;
    import dcache_resp_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dcache_frontend_responder_if fe_if ();
    dcache_frontend_responder_if mem_if ();

`ifdef DCACHE_RESP_STATS_EN
    logic [31:0] s_hits, s_misses, s_writes;
`endif

    dcache_frontend_responder #(.INDEX_BITS(6)) dut (
        .clk   (clk),
        .reset (reset),
        .fe    (fe_if),
        .mem   (mem_if)
`ifdef DCACHE_RESP_STATS_EN
        ,
        .stat_rd_hits   (s_hits),
        .stat_rd_misses (s_misses),
        .stat_writes    (s_writes)
`endif
    );

    int total = 0;
    int bad   = 0;

    logic        r_got;
    int          r_acy, r_nmem, r_xack, r_xmem;
    logic        r_unstable, r_ma_at_ack;
    logic [15:0] r_rd;
    logic [19:1] c_addr;
    logic        c_wr;
    logic [1:0]  c_bsel;
    logic [15:0] c_wdata;
    int          xack;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One frontend request; backend acks after lat cycles of access.
    // Access is held one cycle past fe_ack, like the arbiter does.
    task automatic req(input logic [19:1] a, input logic [15:0] wd,
                       input logic wr, input logic [1:0] bs,
                       input int lat, input logic [15:0] bk);
        logic prev;
        int   seen;
        r_got = 0; r_acy = 0; r_nmem = 0; r_xack = 0; r_xmem = 0;
        r_unstable = 0; r_ma_at_ack = 0; r_rd = '0;
        prev = 0; seen = 0;
        @(negedge clk);
        fe_if.addr    = a;
        fe_if.wdata   = wd;
        fe_if.wr_en   = wr;
        fe_if.bytesel = bs;
        fe_if.access  = 1'b1;
        for (int cyc = 1; cyc <= 60 && !r_got; cyc++) begin
            @(posedge clk); #1;
            if (mem_if.ack) mem_if.ack = 1'b0;
            if (fe_if.ack) begin
                r_got = 1; r_acy = cyc; r_rd = fe_if.rdata;
                r_ma_at_ack = mem_if.access;
            end else if (mem_if.access) begin
                if (!prev) begin
                    r_nmem++;
                    c_addr = mem_if.addr; c_wr = mem_if.wr_en;
                    c_bsel = mem_if.bytesel; c_wdata = mem_if.wdata;
                end else if (c_addr !== mem_if.addr || c_wr !== mem_if.wr_en
                    || c_bsel !== mem_if.bytesel || c_wdata !== mem_if.wdata)
                    r_unstable = 1;
                seen++;
                if (seen == lat) begin
                    mem_if.ack = 1'b1; mem_if.rdata = bk;
                end
            end
            prev = mem_if.access;
        end
        @(posedge clk); #1;
        if (fe_if.ack) r_xack++;
        if (mem_if.access) r_xmem++;
        fe_if.access = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (fe_if.ack) r_xack++;
            if (mem_if.access) r_xmem++;
        end
    endtask

    initial begin
        reset = 1'b1;
        fe_if.addr = '0; fe_if.wdata = '0; fe_if.access = 1'b0;
        fe_if.wr_en = 1'b0; fe_if.bytesel = 2'b00;
        mem_if.ack = 1'b0; mem_if.rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", fe_if.ack, 0);
        chk("rst_rdata", fe_if.rdata, 0);
        chk("rst_maccess", mem_if.access, 0);
        chk("rst_mwr", mem_if.wr_en, 0);
        chk("rst_mbsel", mem_if.bytesel, 2'b11);
        chk("rst_maddr", mem_if.addr, 0);
        chk("rst_mwdata", mem_if.wdata, 0);
        reset = 1'b0;

        // cold read miss
        req(19'h01234, 16'h0, 1'b0, 2'b00, 3, 16'hBEEF);
        chk("rm_got", r_got, 1);
        chk("rm_lat", r_acy, 5);
        chk("rm_rd", r_rd, 16'hBEEF);
        chk("rm_nmem", r_nmem, 1);
        chk("rm_addr", c_addr, 19'h01234);
        chk("rm_wr", c_wr, 0);
        chk("rm_bsel", c_bsel, 2'b11);
        chk("rm_stable", r_unstable, 0);
        chk("rm_ma_drop", r_ma_at_ack, 0);
        chk("rm_xack", r_xack, 0);
        chk("rm_xmem", r_xmem, 0);

        // read hit
        req(19'h01234, 16'h0, 1'b0, 2'b01, 1, 16'h0000);
        chk("rh_got", r_got, 1);
        chk("rh_lat", r_acy, 2);
        chk("rh_rd", r_rd, 16'hBEEF);
        chk("rh_nmem", r_nmem, 0);
        chk("rh_xack", r_xack, 0);

        // low-byte write hit
        req(19'h01234, 16'h12AB, 1'b1, 2'b01, 2, 16'h0000);
        chk("wh_got", r_got, 1);
        chk("wh_lat", r_acy, 4);
        chk("wh_nmem", r_nmem, 1);
        chk("wh_addr", c_addr, 19'h01234);
        chk("wh_wr", c_wr, 1);
        chk("wh_bsel", c_bsel, 2'b01);
        chk("wh_wdata", c_wdata, 16'h12AB);
        chk("wh_xmem", r_xmem, 0);
        req(19'h01234, 16'h0, 1'b0, 2'b11, 1, 16'h0000);
        chk("wh_rd", r_rd, 16'hBEAB);
        chk("wh_rd_nmem", r_nmem, 0);

        // write miss does not allocate
        req(19'h05678, 16'h7777, 1'b1, 2'b11, 1, 16'h0000);
        chk("wm_nmem", r_nmem, 1);
        chk("wm_addr", c_addr, 19'h05678);
        req(19'h05678, 16'h0, 1'b0, 2'b11, 2, 16'h5A5A);
        chk("wm_rd_nmem", r_nmem, 1);
        chk("wm_rd", r_rd, 16'h5A5A);
        chk("wm_rd_lat", r_acy, 4);

        // alias on same index evicts the line
        req(19'h01274, 16'h0, 1'b0, 2'b11, 1, 16'h1111);
        chk("al_nmem", r_nmem, 1);
        chk("al_rd", r_rd, 16'h1111);
        req(19'h01234, 16'h0, 1'b0, 2'b11, 1, 16'hCAFE);
        chk("al_back_nmem", r_nmem, 1);
        chk("al_back_rd", r_rd, 16'hCAFE);

        // bytesel 00 write leaves the line alone
        req(19'h01234, 16'hFFFF, 1'b1, 2'b00, 1, 16'h0000);
        chk("b0_nmem", r_nmem, 1);
        chk("b0_bsel", c_bsel, 2'b00);
        chk("b0_got", r_got, 1);
        req(19'h01234, 16'h0, 1'b0, 2'b11, 1, 16'h0000);
        chk("b0_rd", r_rd, 16'hCAFE);
        chk("b0_rd_nmem", r_nmem, 0);

        // high-byte merge
        req(19'h01234, 16'h3400, 1'b1, 2'b10, 1, 16'h0000);
        req(19'h01234, 16'h0, 1'b0, 2'b01, 1, 16'h0000);
        chk("hb_rd", r_rd, 16'h34FE);
        chk("hb_nmem", r_nmem, 0);

        // top of address space
        req(19'h7FFFF, 16'h0, 1'b0, 2'b11, 1, 16'h0F0F);
        chk("top_addr", c_addr, 19'h7FFFF);
        chk("top_rd", r_rd, 16'h0F0F);
        req(19'h7FFFF, 16'h0, 1'b0, 2'b11, 1, 16'h0000);
        chk("top_hit_nmem", r_nmem, 0);
        chk("top_hit_rd", r_rd, 16'h0F0F);

        // stray backend ack while idle
        @(negedge clk);
        mem_if.ack = 1'b1; mem_if.rdata = 16'hDEAD;
        @(posedge clk); #1;
        mem_if.ack = 1'b0;
        chk("idle_ack_fe", fe_if.ack, 0);
        chk("idle_ack_ma", mem_if.access, 0);

        // reset in the middle of a read miss
        @(negedge clk);
        fe_if.addr = 19'h0ABCD; fe_if.wr_en = 1'b0;
        fe_if.bytesel = 2'b11; fe_if.access = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mr_ma_pre", mem_if.access, 1);
        reset = 1'b1;
        fe_if.access = 1'b0;
        @(posedge clk); #1;
        chk("mr_ma_post", mem_if.access, 0);
        chk("mr_ack_post", fe_if.ack, 0);
        reset = 1'b0;
        xack = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (fe_if.ack) xack++;
        end
        chk("mr_no_ack", xack, 0);
        req(19'h01234, 16'h0, 1'b0, 2'b11, 2, 16'h4321);
        chk("mr_refetch_nmem", r_nmem, 1);
        chk("mr_refetch_rd", r_rd, 16'h4321);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
